uartx: RTL and testbench

- Parametrised next-generation UART engine.
- Full-duplex serial TX/RX with runtime-selectable 8/16/32-bit frames, optional parity and 1 or 2 stop bits.
- Glitch-rejecting start detection; per-direction FIFOs with valid/ready handshakes.
- Sits between the SoC register/bus wrapper and the chip-level TX/RX pads.

---
 rtl/uartx_pkg.sv | 42 ++++
 rtl/uartx_fifo.sv | 55 +++++
 rtl/uartx.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uartx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uartx_pkg.sv
// uartx shared types: frame-width codes, FSM state encodings
// and the payload-width helper.
package uartx_pkg;

    typedef enum logic [1:0] {
        DW8  = 2'b00,
        DW16 = 2'b01,
        DW32 = 2'b10
    } dw_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Code 11 falls back to 8 bits; widths beyond max_dw clamp.
    function automatic logic [5:0] dw_bits(input logic [1:0] dw,
                                           input int max_dw);
        logic [5:0] n;
        case (dw)
            DW16:    n = 6'd16;
            DW32:    n = 6'd32;
            default: n = 6'd8;
        endcase
        if (int'(n) > max_dw)
            n = 6'(max_dw);
        return n;
    endfunction

endpackage

// File: rtl/uartx_fifo.sv
// First-word-fall-through FIFO; a pop in the same cycle frees
// the slot for a push even when full.
module uartx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uartx.sv
// Full-duplex UART engine with 8/16/32-bit frames and FIFOs.
// Define UARTX_LOOPBACK_EN to add the internal TX->RX loopback.
module uartx
    import uartx_pkg::*;
#(
    parameter int MAX_DW     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUDW      = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [BAUDW-1:0]  cfg_baud,
    input  logic [1:0]        cfg_dw,
    input  logic              cfg_par_en,
    input  logic              cfg_par_even,
    input  logic              cfg_stop2,
    input  logic              cfg_lpbk,
    input  logic [MAX_DW-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [MAX_DW-1:0] rx_data,
    output logic              rx_perr,
    output logic              rx_ferr,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_ovf,
    output logic              tx_irq,
    output logic              rx_irq,
    output logic              TX,
    input  logic              RX
);

    localparam int BW = $clog2(MAX_DW);

    logic [MAX_DW-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_pop;
    tx_state_e         tx_state;
    logic [BAUDW-1:0]  tx_cnt;
    logic [BAUDW-1:0]  tx_baud;
    logic [BW-1:0]     tx_bit;
    logic [BW-1:0]     tx_last_bit;
    logic [MAX_DW-1:0] tx_sh;
    logic              tx_par;
    logic              tx_pen;
    logic              tx_stop2;
    logic              tx_line;
    logic              tx_tick;
    logic              tx_last;

    logic [MAX_DW+1:0] rx_head;
    logic [MAX_DW+1:0] rx_wdata;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_src;
    logic              rx_s1;
    logic              rx_s;
    logic              rx_prev;
    rx_state_e         rx_state;
    logic [BAUDW-1:0]  rx_cnt;
    logic [BAUDW-1:0]  rx_baud;
    logic [BW-1:0]     rx_bit;
    logic [BW-1:0]     rx_last_bit;
    logic [MAX_DW-1:0] rx_sh;
    logic              rx_par;
    logic              rx_pen;
    logic              rx_perr_r;
    logic              rx_tick;

`ifdef UARTX_LOOPBACK_EN
    assign TX     = cfg_lpbk ? 1'b1 : tx_line;
    assign rx_src = cfg_lpbk ? tx_line : RX;
`else
    logic unused_lpbk;
    assign unused_lpbk = cfg_lpbk;
    assign TX          = tx_line;
    assign rx_src      = RX;
`endif

    assign tx_ready = !tx_full;

    uartx_fifo #(.W(MAX_DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (hclk),
        .rst   (hreset),
        .push  (tx_valid && tx_ready),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_tick = (tx_cnt == tx_baud);
    assign tx_last = tx_tick &&
                     ((tx_state == TX_STOP1 && !tx_stop2) ||
                      tx_state == TX_STOP2);
    // Popping at the end of the last stop bit gives gapless frames.
    assign tx_pop  = !tx_empty && (tx_state == TX_IDLE || tx_last);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_baud     <= '0;
            tx_bit      <= '0;
            tx_last_bit <= '0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            tx_pen      <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_line     <= 1'b1;
            tx_irq      <= 1'b0;
        end else begin
            tx_irq <= tx_last;
            if (tx_pop) begin
                tx_state    <= TX_START;
                tx_cnt      <= '0;
                tx_bit      <= '0;
                tx_sh       <= tx_head;
                tx_par      <= !cfg_par_even;
                tx_line     <= 1'b0;
                tx_baud     <= cfg_baud;
                tx_last_bit <= BW'(dw_bits(cfg_dw, MAX_DW) - 6'd1);
                tx_pen      <= cfg_par_en;
                tx_stop2    <= cfg_stop2;
            end else if (tx_state != TX_IDLE) begin
                if (!tx_tick) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end else begin
                    tx_cnt <= '0;
                    case (tx_state)
                        TX_START: begin
                            tx_state <= TX_DATA;
                            tx_line  <= tx_sh[0];
                        end
                        TX_DATA: begin
                            tx_par <= tx_par ^ tx_sh[0];
                            if (tx_bit == tx_last_bit) begin
                                if (tx_pen) begin
                                    tx_state <= TX_PARITY;
                                    tx_line  <= tx_par ^ tx_sh[0];
                                end else begin
                                    tx_state <= TX_STOP1;
                                    tx_line  <= 1'b1;
                                end
                            end else begin
                                tx_bit  <= tx_bit + 1'b1;
                                tx_sh   <= tx_sh >> 1;
                                tx_line <= tx_sh[1];
                            end
                        end
                        TX_PARITY: begin
                            tx_state <= TX_STOP1;
                            tx_line  <= 1'b1;
                        end
                        TX_STOP1:
                            tx_state <= tx_stop2 ? TX_STOP2 : TX_IDLE;
                        default:
                            tx_state <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    assign rx_tick  = (rx_cnt == rx_baud);
    assign rx_push  = (rx_state == RX_STOP) && rx_tick;
    assign rx_wdata = {rx_perr_r, !rx_s, rx_sh};

    uartx_fifo #(.W(MAX_DW + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (hclk),
        .rst   (hreset),
        .push  (rx_push),
        .wdata (rx_wdata),
        .pop   (rx_ready),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_valid = !rx_empty;
    assign rx_irq   = rx_valid;
    assign rx_data  = rx_valid ? rx_head[MAX_DW-1:0] : '0;
    assign rx_ferr  = rx_valid && rx_head[MAX_DW];
    assign rx_perr  = rx_valid && rx_head[MAX_DW+1];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            rx_s1       <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_baud     <= '0;
            rx_bit      <= '0;
            rx_last_bit <= '0;
            rx_sh       <= '0;
            rx_par      <= 1'b0;
            rx_pen      <= 1'b0;
            rx_perr_r   <= 1'b0;
            rx_ovf      <= 1'b0;
        end else begin
            rx_s1   <= rx_src;
            rx_s    <= rx_s1;
            rx_prev <= rx_s;
            rx_ovf  <= rx_push && rx_full && !rx_ready;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Start confirm uses the live divisor, then latches it.
                    if (rx_cnt == (cfg_baud >> 1)) begin
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state    <= RX_DATA;
                            rx_cnt      <= '0;
                            rx_bit      <= '0;
                            rx_sh       <= '0;
                            rx_par      <= !cfg_par_even;
                            rx_perr_r   <= 1'b0;
                            rx_baud     <= cfg_baud;
                            rx_last_bit <= BW'(dw_bits(cfg_dw, MAX_DW) - 6'd1);
                            rx_pen      <= cfg_par_en;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt        <= '0;
                        rx_sh[rx_bit] <= rx_s;
                        rx_par        <= rx_par ^ rx_s;
                        if (rx_bit == rx_last_bit)
                            rx_state <= rx_pen ? RX_PARITY : RX_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt    <= '0;
                        rx_perr_r <= (rx_s != rx_par);
                        rx_state  <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartx.sv
// Directed self-checking bench for uartx: TX framing, loopback,
// RX errors, overflow, glitch rejection and mid-frame reset.
module tb_uartx;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [15:0] cfg_baud;
    logic [1:0]  cfg_dw;
    logic        cfg_par_en;
    logic        cfg_par_even;
    logic        cfg_stop2;
    logic        cfg_lpbk;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_perr;
    logic        rx_ferr;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_ovf;
    logic        tx_irq;
    logic        rx_irq;
    logic        TX;
    logic        rx_pin;
    logic        rx_drv;
    logic        ext_lpbk;

    int tests = 0;
    int fails = 0;
    int ovf_cnt = 0;
    int irq_cnt = 0;

    assign rx_pin = ext_lpbk ? TX : rx_drv;

    uartx #(.MAX_DW(32), .FIFO_DEPTH(4), .BAUDW(16)) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .cfg_baud     (cfg_baud),
        .cfg_dw       (cfg_dw),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_even (cfg_par_even),
        .cfg_stop2    (cfg_stop2),
        .cfg_lpbk     (cfg_lpbk),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_perr      (rx_perr),
        .rx_ferr      (rx_ferr),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_ovf       (rx_ovf),
        .tx_irq       (tx_irq),
        .rx_irq       (rx_irq),
        .TX           (TX),
        .RX           (rx_pin)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) begin
        if (rx_ovf) ovf_cnt++;
        if (tx_irq) irq_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] d, input int nb,
                           input logic pinv, input logic sval,
                           input int bt);
        logic p;
        p = !cfg_par_even;
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        rx_drv = 1'b0;
        step(bt);
        for (int i = 0; i < nb; i++) begin
            rx_drv = d[i];
            step(bt);
        end
        if (cfg_par_en) begin
            rx_drv = p ^ pinv;
            step(bt);
        end
        rx_drv = sval;
        step(bt);
        rx_drv = 1'b1;
        step(2 * bt);
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        step(3);
        tests++; if (TX !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", TX); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests++; if (rx_data !== 32'h0) begin fails++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        tests++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin fails++; $display("FAIL reset_err: got %b%b want 00", rx_perr, rx_ferr); end
        tests++; if (rx_ovf !== 1'b0 || tx_irq !== 1'b0) begin fails++; $display("FAIL reset_pulses: got %b%b want 00", rx_ovf, tx_irq); end
        tests++; if (rx_irq !== 1'b0) begin fails++; $display("FAIL reset_rx_irq: got %b want 0", rx_irq); end
        hreset = 1'b0;
        step(2);
    endtask

    task automatic test_tx_basic();
        logic [9:0] frm;
        logic       bad;
        int         base;
        cfg_baud = 16'd15; cfg_dw = 2'b00; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
        frm  = {1'b1, 8'hA5, 1'b0};
        base = irq_cnt;
        tx_data = 32'hA5; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        tests++; if (TX !== 1'b1) begin fails++; $display("FAIL tx_pop_latency: got %b want 1", TX); end
        step(1);
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int c = 0; c < 16; c++) begin
                if (TX !== frm[b]) bad = 1'b1;
                step(1);
            end
            tests++; if (bad) begin fails++; $display("FAIL tx_a5_bit%0d: level wrong, want %b for 16 cycles", b, frm[b]); end
        end
        step(3);
        tests++; if (irq_cnt - base !== 1) begin fails++; $display("FAIL tx_irq_count: got %0d want 1", irq_cnt - base); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [5];
        logic       samp [210];
        logic       e;
        logic       bad;
        int         base;
        int         k;
        w[0] = 8'hFF; w[1] = 8'h00; w[2] = 8'h0F; w[3] = 8'hF0; w[4] = 8'h3C;
        cfg_baud = 16'd3;
        base = irq_cnt;
        for (int i = 0; i < 210; i++) begin
            samp[i] = TX;
            if (i < 5) begin
                tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b want 1", i, tx_ready); end
                tx_valid = 1'b1; tx_data = {24'h0, w[i]};
            end else begin
                tx_valid = 1'b0;
            end
            if (i == 5) begin
                tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: tx_ready got %b want 0", tx_ready); end
            end
            step(1);
        end
        for (int f = 0; f < 5; f++) begin
            bad = 1'b0;
            for (int j = 0; j < 40; j++) begin
                k = j / 4;
                e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : w[f][k-1];
                if (samp[2 + f*40 + j] !== e) bad = 1'b1;
            end
            tests++; if (bad) begin fails++; $display("FAIL b2b_frame%0d: TX pattern wrong for word %h", f, w[f]); end
        end
        bad = (samp[0] !== 1'b1) || (samp[1] !== 1'b1);
        for (int i = 202; i < 210; i++) if (samp[i] !== 1'b1) bad = 1'b1;
        tests++; if (bad) begin fails++; $display("FAIL b2b_idle: TX not high outside frames"); end
        tests++; if (irq_cnt - base !== 5) begin fails++; $display("FAIL b2b_irq: got %0d want 5", irq_cnt - base); end
    endtask

    task automatic test_loopback32();
        int n;
        cfg_baud = 16'd3; cfg_dw = 2'b10; cfg_par_en = 1'b1;
        cfg_par_even = 1'b1; cfg_stop2 = 1'b1;
`ifdef UARTX_LOOPBACK_EN
        cfg_lpbk = 1'b1;
`else
        ext_lpbk = 1'b1;
`endif
        tx_data = 32'hDEADBEEF; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin
            step(1);
            n++;
        end
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL lpbk_timeout: rx_valid got %b want 1", rx_valid); end
        tests++; if (rx_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lpbk_data: got %h want deadbeef", rx_data); end
        tests++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin fails++; $display("FAIL lpbk_err: got %b%b want 00", rx_perr, rx_ferr); end
        pop_rx();
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL lpbk_pop: rx_valid got %b want 0", rx_valid); end
        step(20);
        cfg_lpbk = 1'b0; ext_lpbk = 1'b0;
        cfg_stop2 = 1'b0; cfg_dw = 2'b00; cfg_par_en = 1'b0;
        step(4);
    endtask

    task automatic test_rx_errors();
        cfg_baud = 16'd7; cfg_dw = 2'b00; cfg_par_en = 1'b1; cfg_par_even = 1'b0;
        send_rx(32'h3C, 8, 1'b1, 1'b1, 8);
        tests++; if (rx_valid !== 1'b1 || rx_data !== 32'h3C) begin fails++; $display("FAIL perr_data: got v=%b %h want v=1 3c", rx_valid, rx_data); end
        tests++; if (rx_perr !== 1'b1 || rx_ferr !== 1'b0) begin fails++; $display("FAIL perr_flags: got p=%b f=%b want p=1 f=0", rx_perr, rx_ferr); end
        pop_rx();
        send_rx(32'h3C, 8, 1'b0, 1'b0, 8);
        tests++; if (rx_valid !== 1'b1 || rx_data !== 32'h3C) begin fails++; $display("FAIL ferr_data: got v=%b %h want v=1 3c", rx_valid, rx_data); end
        tests++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b1) begin fails++; $display("FAIL ferr_flags: got p=%b f=%b want p=0 f=1", rx_perr, rx_ferr); end
        pop_rx();
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL err_drain: rx_valid got %b want 0", rx_valid); end
        cfg_par_en = 1'b0; cfg_par_even = 1'b1;
    endtask

    task automatic test_rx_overflow();
        logic [7:0] w [5];
        int         base;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55;
        cfg_baud = 16'd7; cfg_par_en = 1'b0; rx_ready = 1'b0;
        base = ovf_cnt;
        for (int i = 0; i < 4; i++) send_rx({24'h0, w[i]}, 8, 1'b0, 1'b1, 8);
        tests++; if (ovf_cnt - base !== 0) begin fails++; $display("FAIL ovf_early: got %0d pulses want 0", ovf_cnt - base); end
        send_rx({24'h0, w[4]}, 8, 1'b0, 1'b1, 8);
        tests++; if (ovf_cnt - base !== 1) begin fails++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rx_valid !== 1'b1 || rx_data !== {24'h0, w[i]}) begin fails++; $display("FAIL ovf_entry%0d: got v=%b %h want v=1 %h", i, rx_valid, rx_data, w[i]); end
            pop_rx();
        end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovf_drain: rx_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        cfg_baud = 16'd15; cfg_par_en = 1'b0;
        rx_drv = 1'b0;
        step(3);
        rx_drv = 1'b1;
        step(40);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_push: rx_valid got %b want 0", rx_valid); end
        send_rx(32'h81, 8, 1'b0, 1'b1, 16);
        tests++; if (rx_valid !== 1'b1 || rx_data !== 32'h81) begin fails++; $display("FAIL glitch_then_81: got v=%b %h want v=1 81", rx_valid, rx_data); end
        tests++; if (rx_ferr !== 1'b0) begin fails++; $display("FAIL glitch_ferr: got %b want 0", rx_ferr); end
        pop_rx();
    endtask

    task automatic test_mid_reset();
        logic [9:0] frm;
        int         base;
        cfg_baud = 16'd7; cfg_dw = 2'b00; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
        base = irq_cnt;
        tx_data = 32'h0F; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(1);
        step(43);
        tests++; if (TX !== 1'b0) begin fails++; $display("FAIL midrst_bit4: TX got %b want 0", TX); end
        hreset = 1'b1;
        step(1);
        tests++; if (TX !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b want 1", TX); end
        tests++; if (tx_ready !== 1'b1 || tx_irq !== 1'b0) begin fails++; $display("FAIL midrst_flags: ready=%b irq=%b want 1 0", tx_ready, tx_irq); end
        hreset = 1'b0;
        step(100);
        tests++; if (irq_cnt - base !== 0 || TX !== 1'b1) begin fails++; $display("FAIL midrst_quiet: irqs=%0d TX=%b want 0 1", irq_cnt - base, TX); end
        frm = {1'b1, 8'h55, 1'b0};
        tx_data = 32'h55; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(1);
        step(4);
        for (int b = 0; b < 10; b++) begin
            tests++; if (TX !== frm[b]) begin fails++; $display("FAIL midrst_55_bit%0d: got %b want %b", b, TX, frm[b]); end
            step(8);
        end
        step(4);
        tests++; if (irq_cnt - base !== 1) begin fails++; $display("FAIL midrst_irq: got %0d want 1", irq_cnt - base); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1;
        cfg_baud = 16'd15; cfg_dw = 2'b00; cfg_par_en = 1'b0;
        cfg_par_even = 1'b1; cfg_stop2 = 1'b0; cfg_lpbk = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        rx_drv = 1'b1; ext_lpbk = 1'b0;
        #1;
        test_reset();
        test_tx_basic();
        test_back_to_back();
        test_loopback32();
        test_rx_errors();
        test_rx_overflow();
        test_glitch();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
